// File: rtl/reset_sequencer_tmr.sv
// Reset sequencer for the OptoHybrid core. It waits for MMCM lock and GBT link, holds reset, then
// releases the reset domains one after another. FSM state and counter can be triplicated and voted.
module reset_sequencer_tmr #(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter bit TMR_EN         = 1'b1,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     soft_reset_i,
  input  logic                     mmcms_locked_i,
  input  logic                     gbt_rxready_i,
  input  logic                     gbt_rxvalid_i,
  input  logic                     gbt_txready_i,
  input  logic [2:0]               tmr_inject_i,
  output logic [NUM_DOMAINS-1:0]   domain_reset_o,
  output logic                     ready_o,
  output logic                     tmr_err_o,
  output logic [ERR_CNT_WIDTH-1:0] tmr_err_cnt_o
);

  localparam int REL_SPAN = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int CNT_MAX  = (HOLD_CYCLES > REL_SPAN) ? HOLD_CYCLES : REL_SPAN;
  localparam int CW       = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'((NUM_DOMAINS - 1) * STAGGER_CYCLES);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_WAIT_LINK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                   state_v;
  logic   [CW-1:0]          cnt_v;
  state_t                   state_d;
  logic   [CW-1:0]          cnt_d;
  logic                     disagree;
  logic                     link_ok;
  logic [NUM_DOMAINS-1:0]   domain_reset_d, domain_reset_q;
  logic                     ready_d, ready_q;
  logic                     tmr_err_d, tmr_err_q;
  logic [ERR_CNT_WIDTH-1:0] tmr_err_cnt_d, tmr_err_cnt_q;

  assign link_ok = gbt_rxready_i & gbt_rxvalid_i & gbt_txready_i;

  // Every copy is rewritten from the voted value, so a single upset copy is repaired next edge.
  if (TMR_EN) begin : g_tmr
    state_t          state_q [3];
    logic   [CW-1:0] cnt_q   [3];

    always_comb begin
      state_v = state_t'((state_q[0] & state_q[1]) | (state_q[0] & state_q[2]) |
                         (state_q[1] & state_q[2]));
      cnt_v   = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
      disagree = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if ((state_q[i] != state_v) || (cnt_q[i] != cnt_v)) disagree = 1'b1;
      end
    end

    always_ff @(posedge clock_i) begin
      for (int i = 0; i < 3; i++) begin
        if (!reset_n_i) begin
          state_q[i] <= ST_WAIT_LOCK;
          cnt_q[i]   <= '0;
        end else begin
          state_q[i] <= state_d;
          cnt_q[i]   <= cnt_d ^ CW'(tmr_inject_i[i]);
        end
      end
    end
  end else begin : g_single
    state_t          state_q;
    logic   [CW-1:0] cnt_q;
    logic            unused_inject;

    assign unused_inject = ^tmr_inject_i;

    always_comb begin
      state_v  = state_q;
      cnt_v    = cnt_q;
      disagree = 1'b0;
    end

    always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
        state_q <= ST_WAIT_LOCK;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  // Terminal compares use >= so a voted counter knocked past its limit still leaves the state.
  always_comb begin
    state_d = state_v;
    cnt_d   = cnt_v;
    if (!mmcms_locked_i) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_v)
        ST_WAIT_LOCK: begin
          state_d = ST_WAIT_LINK;
          cnt_d   = '0;
        end
        ST_WAIT_LINK: begin
          if (link_ok) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD, ST_RELEASE: begin
          if (soft_reset_i) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else if (!link_ok) begin
            state_d = ST_WAIT_LINK;
            cnt_d   = '0;
          end else if (state_v == ST_HOLD) begin
            if (cnt_v >= HOLD_LAST) begin
              state_d = ST_RELEASE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_v + CW'(1);
            end
          end else if (cnt_v >= REL_LAST) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_v + CW'(1);
          end
        end
        ST_RUN: begin
          if (soft_reset_i) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    domain_reset_d = '1;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if ((state_d == ST_RUN) ||
          ((state_d == ST_RELEASE) && (cnt_d >= CW'(k * STAGGER_CYCLES)))) begin
        domain_reset_d[k] = 1'b0;
      end
    end
    ready_d = (state_d == ST_RUN) || ((state_d == ST_RELEASE) && (cnt_d >= REL_LAST));
    tmr_err_d     = disagree;
    tmr_err_cnt_d = tmr_err_cnt_q;
    if (disagree && !(&tmr_err_cnt_q)) tmr_err_cnt_d = tmr_err_cnt_q + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      domain_reset_q <= '1;
      ready_q        <= 1'b0;
      tmr_err_q      <= 1'b0;
      tmr_err_cnt_q  <= '0;
    end else begin
      domain_reset_q <= domain_reset_d;
      ready_q        <= ready_d;
      tmr_err_q      <= tmr_err_d;
      tmr_err_cnt_q  <= tmr_err_cnt_d;
    end
  end

  assign domain_reset_o = domain_reset_q;
  assign ready_o        = ready_q;
  assign tmr_err_o      = tmr_err_q;
  assign tmr_err_cnt_o  = tmr_err_cnt_q;

endmodule
